menu_input_ctrl: RTL

MENU_INPUT_CTRL -- requirements
Module: menu_input_ctrl

---
 rtl/menu_input_ctrl_if.sv | 20 ++
 rtl/menu_input_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/menu_input_ctrl_if.sv
// menu_input_ctrl_if: joystick/button inputs and pause-menu outputs of the menu input controller
interface menu_input_ctrl_if;
    logic btn_raw;
    logic up_raw;
    logic down_raw;
    logic menu_active;
    logic enter;
    logic value;
    logic btn_level;

    modport master (
        output btn_raw, up_raw, down_raw, menu_active,
        input  enter, value, btn_level
    );

    modport slave (
        input  btn_raw, up_raw, down_raw, menu_active,
        output enter, value, btn_level
    );
endinterface

// File: rtl/menu_input_ctrl.sv
// menu_input_ctrl: synchronizes and debounces button/joystick inputs, drives enter pulse and pause-menu selection
module menu_input_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          CNT_W           = 16
) (
    input logic             clock,
    input logic             reset,
    menu_input_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] rise;
    logic       btn_lvl_n;
    logic       prev_ma;
    logic       ma_rise;
    logic       enter_q;
    logic       value_q;
    logic       value_n;
    logic       level_q;

    // bit 0 = button, bit 1 = up, bit 2 = down
    assign raw = {bus.down_raw, bus.up_raw, bus.btn_raw};

    // two-flop synchronizer for each raw contact
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar d = 0; d < 3; d++) begin : g_db
        db_state_t        st;
        db_state_t        st_n;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_n;
        logic [CNT_W-1:0] cnt_inc;
        logic             in;
        logic             at_last;
        logic             rise_i;

        assign in      = sync2[d];
        assign at_last = cnt == LAST;
        assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

        // debouncer state and stability counter
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
            end
        end

        // a level change is accepted only after the input stays stable through a full count
        always_comb begin
            st_n   = st;
            cnt_n  = cnt;
            rise_i = 1'b0;
            case (st)
                IDLE: if (in) begin
                    st_n  = PRESS_WAIT;
                    cnt_n = '0;
                end
                PRESS_WAIT: if (!in) st_n = IDLE;
                    else if (at_last) begin
                        st_n   = PRESSED;
                        rise_i = 1'b1;
                    end else cnt_n = cnt_inc;
                PRESSED: if (!in) begin
                    st_n  = RELEASE_WAIT;
                    cnt_n = '0;
                end
                RELEASE_WAIT: if (in) st_n = PRESSED;
                    else if (at_last) st_n = IDLE;
                    else cnt_n = cnt_inc;
                default: st_n = IDLE;
            endcase
        end

        assign rise[d] = rise_i;

        if (d == 0) begin : g_lvl
            assign btn_lvl_n = (st_n == PRESSED) || (st_n == RELEASE_WAIT);
        end
    end

    assign ma_rise = bus.menu_active & ~prev_ma;

    // menu entry forces Continue; a lone up/down event while the menu is shown selects
    always_comb begin
        value_n = ma_rise                                     ? 1'b0 :
                  (bus.menu_active && rise[1] && !rise[2])    ? 1'b0 :
                  (bus.menu_active && rise[2] && !rise[1])    ? 1'b1 :
                                                                value_q;
    end

    // enter and value are registered on the same edge so the consumer sees a consistent pair
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_ma <= 1'b0;
            enter_q <= 1'b0;
            value_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            prev_ma <= bus.menu_active;
            enter_q <= rise[0];
            value_q <= value_n;
            level_q <= btn_lvl_n;
        end
    end

    assign bus.enter     = enter_q;
    assign bus.value     = value_q;
    assign bus.btn_level = level_q;
endmodule
